// File: rtl/uart_tx_pkg.sv
// Shared register map, bit positions, FSM encoding and reset constants
// for the memory-mapped UART transmitter.
package uart_tx_pkg;

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;
  localparam logic [3:0] ADDR_CTRL    = 4'hC;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [15:0] DEFAULT_DIV = 16'd433;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is presented combinationally.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o   = wptr_q - rptr_q;
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rptr_q[AW-1:0]];

  // Pointer advance
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push_s};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop_s};
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q <= {(AW+1){1'b0}};
      rptr_q <= {(AW+1){1'b0}};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, baud timer and frame FSM
// wrapped around a byte FIFO. Bus signals arrive already registered.
module uart_tx_periph #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = uart_tx_pkg::DEFAULT_DIV
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        csb_i,
  input  logic        wen_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  import uart_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d, baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d, tx_q, tx_d, irq_q, irq_d;

  logic        wr_s, push_req_s, push_ok_s, pop_s, ovf_clr_s, bit_end_s;
  logic        wr_div_s, wr_ctrl_s, full_s, empty_s, busy_s;
  logic [7:0]  head_s;
  logic [CW:0] count_s, count_next_s;
  logic [3:0]  reg_addr_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign reg_addr_s = {addr_i[3:2], 2'b00};
  assign wr_s       = ~csb_i & ~wen_i;
  assign push_req_s = wr_s & (reg_addr_s == ADDR_TXDATA) & wmask_i[0];
  assign push_ok_s  = push_req_s & ~full_s;
  assign ovf_clr_s  = wr_s & (reg_addr_s == ADDR_STATUS) & wmask_i[0] & data_i[STAT_OVF];
  assign wr_div_s   = wr_s & (reg_addr_s == ADDR_BAUDDIV);
  assign wr_ctrl_s  = wr_s & (reg_addr_s == ADDR_CTRL) & wmask_i[0];
  assign unused_s   = ^{data_i[31:16], addr_i[1:0], wmask_i[3:2]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_req_s),
    .pop_i   (pop_s),
    .wdata_i (data_i[7:0]),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // A set on a full push wins over a simultaneous clear
  assign ovf_d  = (push_req_s & full_s) | (ovf_q & ~ovf_clr_s);
  assign div_d  = {(wr_div_s & wmask_i[1]) ? data_i[15:8] : div_q[15:8],
                   (wr_div_s & wmask_i[0]) ? data_i[7:0]  : div_q[7:0]};
  assign ctrl_d = wr_ctrl_s ? data_i[1:0] : ctrl_q;

  assign bit_end_s    = (baud_q == 16'd0);
  assign busy_s       = (state_q != ST_IDLE) | ~empty_s;
  assign count_next_s = count_s + {{CW{1'b0}}, push_ok_s} - {{CW{1'b0}}, pop_s};

  // Frame sequencing: next state, baud/bit counters, shifter and FIFO pop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_TX_EN] && !empty_s) begin
          state_d = ST_START;
          pop_s   = 1'b1;
          shift_d = head_s;
          baud_d  = div_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
          baud_d  = div_q;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_d  = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s && ctrl_q[CTRL_TX_EN] && !empty_s) begin
          state_d = ST_START;
          pop_s   = 1'b1;
          shift_d = head_s;
          baud_d  = div_q;
        end else if (bit_end_s) begin
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin and interrupt values for the next cycle, taken from next-state values
  always_comb begin
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    irq_d = ctrl_d[CTRL_IRQ_EN] & (count_next_s == {(CW+1){1'b0}}) & (state_d == ST_IDLE);
  end

  // Combinational read mux; writes and deselected cycles return zero
  always_comb begin
    rdata_s = 32'd0;
    if (!csb_i && wen_i) begin
      case (reg_addr_s)
        ADDR_STATUS: begin
          rdata_s[STAT_BUSY]                 = busy_s;
          rdata_s[STAT_FULL]                 = full_s;
          rdata_s[STAT_EMPTY]                = empty_s;
          rdata_s[STAT_OVF]                  = ovf_q;
          rdata_s[STAT_CNT_LSB +: (CW+1)]    = count_s;
        end
        ADDR_BAUDDIV: rdata_s[15:0] = div_q;
        ADDR_CTRL:    rdata_s[1:0]  = ctrl_q;
        default:      rdata_s       = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign data_o = rdata_s;
  assign tx_o   = tx_q;
  assign irq_o  = irq_q;

  // State, configuration and output registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      div_q   <= DEFAULT_DIV;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      ctrl_q  <= 2'd0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed + randomized bench for uart_tx_periph; the line is compared cycle by
// cycle against an ideal 8N1 waveform computed from the queued bytes.
module tb_uart_tx_periph;

  localparam int DEPTH = 8;

  logic        clk_i   = 1'b0;
  logic        reset_i = 1'b0;
  logic        csb_i   = 1'b1;
  logic        wen_i   = 1'b1;
  logic [3:0]  addr_i  = 4'h0;
  logic [31:0] data_i  = 32'd0;
  logic [3:0]  wmask_i = 4'h0;
  logic [31:0] data_o;
  logic        tx_o, irq_o;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  int          m_cnt;
  logic        m_ovf;
  logic [15:0] m_div;

  uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .csb_i   (csb_i),
    .wen_i   (wen_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .wmask_i (wmask_i),
    .data_o  (data_o),
    .tx_o    (tx_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_exp(input int cnt, input logic ovf, input logic fsm_busy);
    logic [31:0] s;
    s       = 32'd0;
    s[15:8] = cnt[7:0];
    s[3]    = ovf;
    s[2]    = (cnt == 0);
    s[1]    = (cnt == DEPTH);
    s[0]    = fsm_busy || (cnt != 0);
    return s;
  endfunction

  // Ideal line level k cycles after the first start bit for the head nframes bytes.
  function automatic logic exp_tx(input int k, input int div, input int nframes);
    int         bl, fl, f, b;
    logic [7:0] by;
    bl = div + 1;
    fl = 10 * bl;
    if (k >= nframes * fl) return 1'b1;
    f  = k / fl;
    b  = (k % fl) / bl;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    by = exp_q[f];
    return by[b-1];
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk_i);
    csb_i = 1'b0; wen_i = 1'b0; addr_i = a; data_i = d; wmask_i = m;
    #1;
    check("write data_o", data_o, 32'd0);
    @(negedge clk_i);
    csb_i = 1'b1; wen_i = 1'b1; data_i = 32'd0; wmask_i = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    csb_i = 1'b0; wen_i = 1'b1; addr_i = a;
    #1;
    d = data_o;
    csb_i = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    wr(4'h0, {24'hFFFFFF, b}, 4'h1);
    if (m_cnt == DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      exp_q.push_back(b);
      m_cnt++;
    end
  endtask

  task automatic run_frames(input string tag, input int div, input int nframes, input int extra,
                            input logic chk_irq, input logic dis_mid);
    int         i, total;
    logic [7:0] b;
    i = 0;
    while (tx_o !== 1'b0 && i < 300) begin
      @(negedge clk_i);
      i++;
    end
    check({tag, " start seen"}, {31'd0, tx_o === 1'b0}, 32'd1);
    total = nframes * 10 * (div + 1) + extra;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clk_i);
      if (dis_mid && k == 0) begin
        csb_i = 1'b0; wen_i = 1'b0; addr_i = 4'hC; data_i = 32'd0; wmask_i = 4'h1;
      end
      if (dis_mid && k == 1) begin
        csb_i = 1'b1; wen_i = 1'b1; wmask_i = 4'h0;
      end
      check($sformatf("%s tx k=%0d", tag, k), {31'd0, tx_o}, {31'd0, exp_tx(k, div, nframes)});
      if (chk_irq)
        check($sformatf("%s irq k=%0d", tag, k), {31'd0, irq_o},
              (k < nframes * 10 * (div + 1)) ? 32'd0 : 32'd1);
    end
    for (int n = 0; n < nframes; n++) b = exp_q.pop_front();
    m_cnt -= nframes;
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] dv;
    logic [3:0]  mk;
    int          div;

    m_cnt = 0; m_ovf = 1'b0; m_div = 16'd433;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Reset state
    rd(4'h8, r); check("reset bauddiv", r, 32'd433);
    rd(4'h4, r); check("reset status", r, status_exp(0, 1'b0, 1'b0));
    rd(4'hC, r); check("reset ctrl", r, 32'd0);
    check("reset tx", {31'd0, tx_o}, 32'd1);
    check("reset irq", {31'd0, irq_o}, 32'd0);
    check("deselected data_o", data_o, 32'd0);
    rd(4'h0, r); check("txdata reads zero", r, 32'd0);

    // Byte-masked divisor writes
    repeat (4) begin
      dv = 16'($urandom);
      mk = 4'($urandom);
      wr(4'h8, {16'hFFFF, dv}, mk);
      if (mk[0]) m_div[7:0]  = dv[7:0];
      if (mk[1]) m_div[15:8] = dv[15:8];
      rd(4'h8, r); check("bauddiv masked", r, {16'd0, m_div});
    end

    // Single frame of 0xA5
    wr(4'h8, 32'd3, 4'hF);
    wr(4'hC, 32'd1, 4'h1);
    push(8'hA5);
    run_frames("single", 3, 1, 0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("single idle tx", {31'd0, tx_o}, 32'd1);
    rd(4'h4, r); check("single status after", r, status_exp(0, 1'b0, 1'b0));

    // Back-to-back frames with no idle gap
    wr(4'hC, 32'd0, 4'h1);
    push(8'h01);
    push(8'h80);
    rd(4'h4, r); check("b2b status queued", r, status_exp(2, 1'b0, 1'b0));
    wr(4'hC, 32'd1, 4'h1);
    rd(4'h4, r); check("b2b count before pop", r, status_exp(2, 1'b0, 1'b0));
    @(negedge clk_i);
    rd(4'h4, r); check("b2b count after pop", r, status_exp(1, 1'b0, 1'b1));
    run_frames("b2b", 3, 2, 0, 1'b0, 1'b0);
    @(negedge clk_i);
    rd(4'h4, r); check("b2b status after", r, status_exp(0, 1'b0, 1'b0));

    // Random bytes at a random divisor
    div = $urandom_range(1, 4);
    wr(4'hC, 32'd0, 4'h1);
    wr(4'h8, div, 4'h3);
    repeat (3) push(8'($urandom));
    wr(4'hC, 32'd1, 4'h1);
    run_frames("rand", div, 3, 2, 1'b0, 1'b0);

    // Overflow: nine pushes into eight entries
    wr(4'hC, 32'd0, 4'h1);
    repeat (9) push(8'($urandom));
    rd(4'h4, r); check("ovf status", r, status_exp(m_cnt, m_ovf, 1'b0));
    wr(4'h4, 32'h8, 4'h1);
    m_ovf = 1'b0;
    rd(4'h4, r); check("ovf cleared", r, status_exp(m_cnt, m_ovf, 1'b0));
    wr(4'h8, 32'd1, 4'h3);
    wr(4'hC, 32'd1, 4'h1);
    run_frames("drain", 1, 8, 2, 1'b0, 1'b0);
    rd(4'h4, r); check("drain status", r, status_exp(0, 1'b0, 1'b0));

    // Interrupt follows empty-and-idle
    wr(4'hC, 32'd3, 4'h1);
    check("irq idle empty", {31'd0, irq_o}, 32'd1);
    push(8'($urandom));
    check("irq after push", {31'd0, irq_o}, 32'd0);
    run_frames("irq", 1, 1, 3, 1'b1, 1'b0);

    // Disable mid-frame with two bytes queued
    wr(4'hC, 32'd0, 4'h1);
    push(8'($urandom));
    push(8'h00);
    wr(4'h8, 32'd3, 4'h3);
    wr(4'hC, 32'd1, 4'h1);
    run_frames("disable", 3, 1, 20, 1'b0, 1'b1);
    rd(4'h4, r); check("disable status", r, status_exp(1, 1'b0, 1'b0));
    check("disable irq", {31'd0, irq_o}, 32'd0);

    // Asynchronous reset in the middle of the remaining 0x00 frame
    wr(4'hC, 32'd1, 4'h1);
    begin
      int i;
      i = 0;
      while (tx_o !== 1'b0 && i < 300) begin
        @(negedge clk_i);
        i++;
      end
    end
    repeat (6) @(negedge clk_i);
    check("pre-reset data bit", {31'd0, tx_o}, {31'd0, exp_tx(6, 3, 1)});
    #2 reset_i = 1'b0;
    #1 check("async reset tx", {31'd0, tx_o}, 32'd1);
    @(negedge clk_i);
    rd(4'h4, r); check("async reset status", r, status_exp(0, 1'b0, 1'b0));
    rd(4'h8, r); check("async reset bauddiv", r, 32'd433);
    check("async reset irq", {31'd0, irq_o}, 32'd0);
    reset_i = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    repeat (3) @(negedge clk_i);
    check("post reset tx", {31'd0, tx_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
